// File: rtl/npu_pkg.sv
// Shared NPU sequencing types: controller state encoding and kernel tap-count helper.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_SWEEP  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_KERNEL_SIZE = 3;

  // Taps per window for a square kernel of edge k.
  function automatic int unsigned nt_of(input int unsigned k);
    return k * k;
  endfunction

  localparam int unsigned DEF_NT = nt_of(DEF_KERNEL_SIZE);

endpackage

// File: rtl/kernel_seq_ctrl_tap_counter.sv
// Mod-NT counter with enable, synchronous clear and first/last/wrap flags.
module tap_counter #(
  parameter int unsigned NT = 9,
  parameter int unsigned W  = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         first_o,
  output logic         last_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign first_o = (count_q == '0);
  assign last_o  = (count_q == W'(NT - 1));
  assign wrap_o  = en_i & last_o & ~clr_i;

endmodule

// File: rtl/kernel_seq_ctrl.sv
// Kernel weight buffer sequencer: loads NT weights, then sweeps the read port
// tap-by-tap for a programmed number of windows.
module kernel_seq_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE       = 3,
  parameter int unsigned KERNEL_ADDR_WIDTH = 5,
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned WIN_CNT_WIDTH     = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         load_start,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [WEIGHT_WIDTH-1:0]      w_data,
  output logic                         kr_wr_en,
  output logic [KERNEL_ADDR_WIDTH-1:0] kr_wr_addr,
  output logic [WEIGHT_WIDTH-1:0]      kr_wr_data,
  input  logic                         run_start,
  input  logic [WIN_CNT_WIDTH-1:0]     num_windows,
  output logic [KERNEL_ADDR_WIDTH-1:0] kr_rd_addr,
  output logic                         tap_valid,
  input  logic                         tap_ready,
  output logic                         tap_first,
  output logic                         tap_last,
  output logic                         kernel_loaded,
  output logic                         busy,
  output logic                         done,
  output logic                         err_no_kernel
);

  localparam int unsigned NT = nt_of(KERNEL_SIZE);

  seq_state_e                 state_q;
  logic                       kernel_loaded_q;
  logic                       done_q;
  logic                       err_q;
  logic [WIN_CNT_WIDTH-1:0]   win_q;

  logic                         in_idle, in_load, in_loaded, in_sweep;
  logic                         load_go, run_go, tap_hs;
  logic [KERNEL_ADDR_WIDTH-1:0] lc, tc;
  logic                         lc_first, lc_last, lc_wrap;
  logic                         tc_first, tc_last, tc_wrap;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_load   = (state_q == ST_LOAD);
  assign in_loaded = (state_q == ST_LOADED);
  assign in_sweep  = (state_q == ST_SWEEP);

  // Load has priority over run; a resident kernel always leaves lc parked at 0.
  assign load_go = load_start & (in_idle | in_loaded);
  assign run_go  = run_start & ~load_start & in_loaded & lc_first;
  assign tap_hs  = tap_valid & tap_ready;

  tap_counter #(.NT(NT), .W(KERNEL_ADDR_WIDTH)) u_lc (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (load_go),
    .en_i    (kr_wr_en),
    .count_o (lc),
    .first_o (lc_first),
    .last_o  (lc_last),
    .wrap_o  (lc_wrap)
  );

  tap_counter #(.NT(NT), .W(KERNEL_ADDR_WIDTH)) u_tc (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (run_go),
    .en_i    (tap_hs),
    .count_o (tc),
    .first_o (tc_first),
    .last_o  (tc_last),
    .wrap_o  (tc_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      kernel_loaded_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      win_q           <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q <= ST_LOAD;
          end else if (run_start) begin
            err_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (lc_wrap) begin
            state_q         <= ST_LOADED;
            kernel_loaded_q <= 1'b1;
            done_q          <= 1'b1;
          end
        end
        ST_LOADED: begin
          if (load_start) begin
            state_q         <= ST_LOAD;
            kernel_loaded_q <= 1'b0;
          end else if (run_go) begin
            if (num_windows == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_SWEEP;
              win_q   <= num_windows;
            end
          end
        end
        ST_SWEEP: begin
          // Window count steps on each tap wrap; the final wrap ends the sweep.
          if (tc_wrap) begin
            win_q <= win_q - WIN_CNT_WIDTH'(1);
            if (win_q == WIN_CNT_WIDTH'(1)) begin
              state_q <= ST_LOADED;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_ready       = in_load;
  assign kr_wr_en      = in_load & w_valid;
  assign kr_wr_addr    = in_load ? lc : '0;
  assign kr_wr_data    = in_load ? w_data : '0;
  assign tap_valid     = in_sweep;
  assign kr_rd_addr    = in_sweep ? tc : '0;
  assign tap_first     = in_sweep & tc_first;
  assign tap_last      = in_sweep & tc_last;
  assign kernel_loaded = kernel_loaded_q;
  assign busy          = in_load | in_sweep;
  assign done          = done_q;
  assign err_no_kernel = err_q;

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// Directed bench for kernel_seq_ctrl with a per-cycle behavioural model compare.
module tb_kernel_seq_ctrl;

  localparam int unsigned KS = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned NT = KS * KS;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          load_start, w_valid, w_ready;
  logic [WW-1:0] w_data;
  logic          kr_wr_en;
  logic [AW-1:0] kr_wr_addr;
  logic [WW-1:0] kr_wr_data;
  logic          run_start;
  logic [CW-1:0] num_windows;
  logic [AW-1:0] kr_rd_addr;
  logic          tap_valid, tap_ready, tap_first, tap_last;
  logic          kernel_loaded, busy, done, err_no_kernel;
  logic [26:0]   outs_all;

  kernel_seq_ctrl #(
    .KERNEL_SIZE(KS), .KERNEL_ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW), .WIN_CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .load_start(load_start), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .kr_wr_en(kr_wr_en), .kr_wr_addr(kr_wr_addr),
    .kr_wr_data(kr_wr_data), .run_start(run_start), .num_windows(num_windows),
    .kr_rd_addr(kr_rd_addr), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_first(tap_first), .tap_last(tap_last), .kernel_loaded(kernel_loaded),
    .busy(busy), .done(done), .err_no_kernel(err_no_kernel)
  );

  always #5 i_clk = ~i_clk;

  assign outs_all = {w_ready, kr_wr_en, kr_wr_addr, kr_wr_data, kr_rd_addr, tap_valid,
                     tap_first, tap_last, kernel_loaded, busy, done, err_no_kernel};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 kernel resident, 3 sweeping (global tap index).
  int m_mode, m_idx, m_tap, m_total;
  bit m_loaded, m_done, m_err, m_valid;

  always @(posedge i_clk) begin : model
    int mode, idx, tap, total;
    bit kl, dn, er;
    mode = m_mode; idx = m_idx; tap = m_tap; total = m_total; kl = m_loaded;
    dn = 1'b0; er = 1'b0;
    if (i_rst) begin
      mode = 0; idx = 0; tap = 0; total = 0; kl = 1'b0;
    end else begin
      case (mode)
        0: if (load_start) mode = 1; else if (run_start) er = 1'b1;
        1: if (w_valid) begin
             idx++;
             if (idx == NT) begin idx = 0; mode = 2; kl = 1'b1; dn = 1'b1; end
           end
        2: if (load_start) begin
             mode = 1; kl = 1'b0;
           end else if (run_start) begin
             if (int'(num_windows) == 0) dn = 1'b1;
             else begin mode = 3; tap = 0; total = NT * int'(num_windows); end
           end
        default: if (tap_ready) begin
             tap++;
             if (tap == total) begin mode = 2; dn = 1'b1; end
           end
      endcase
    end
    m_mode <= mode; m_idx <= idx; m_tap <= tap; m_total <= total;
    m_loaded <= kl; m_done <= dn; m_err <= er; m_valid <= 1'b1;
  end

  always @(negedge i_clk) begin : compare
    bit ld, sw;
    if (m_valid) begin
      ld = (m_mode == 1);
      sw = (m_mode == 3);
      chk("w_ready", w_ready, ld);
      chk("kr_wr_en", kr_wr_en, ld & w_valid);
      chk("kr_wr_addr", kr_wr_addr, ld ? m_idx : 0);
      chk("kr_wr_data", kr_wr_data, ld ? w_data : 0);
      chk("tap_valid", tap_valid, sw);
      chk("kr_rd_addr", kr_rd_addr, sw ? (m_tap % NT) : 0);
      chk("tap_first", tap_first, sw && (m_tap % NT == 0));
      chk("tap_last", tap_last, sw && (m_tap % NT == NT - 1));
      chk("kernel_loaded", kernel_loaded, m_loaded);
      chk("busy", busy, ld | sw);
      chk("done", done, m_done);
      chk("err_no_kernel", err_no_kernel, m_err);
    end
  end

  // Observed transactions and a shadow of the weight buffer.
  int wr_addr_q[$], wr_data_q[$], tp_addr_q[$], tp_first_q[$], tp_last_q[$];
  logic [WW-1:0] kbuf [0:31];

  always @(posedge i_clk) begin
    if (!i_rst) begin
      if (kr_wr_en) begin
        wr_addr_q.push_back(int'(kr_wr_addr));
        wr_data_q.push_back(int'(kr_wr_data));
        kbuf[kr_wr_addr] <= kr_wr_data;
      end
      if (tap_valid && tap_ready) begin
        tp_addr_q.push_back(int'(kr_rd_addr));
        tp_first_q.push_back(int'(tap_first));
        tp_last_q.push_back(int'(tap_last));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete();
    tp_addr_q.delete(); tp_first_q.delete(); tp_last_q.delete();
  endtask

  task automatic load_kernel(input bit gap);
    bit hs;
    int n, budget;
    n = 0; budget = 0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    while (n < NT && budget < 100) begin
      if (gap && (budget % 2 == 1)) begin w_valid = 1'b0; w_data = 8'hEE; end
      else begin w_valid = 1'b1; w_data = WW'(n + 1); end
      hs = w_valid && w_ready;
      tick(); budget++;
      if (hs) n++;
    end
    w_valid = 1'b0; w_data = '0;
    chk("load_handshakes", n, NT);
    chk("load_done_lit", done, 1);
    chk("load_kernel_loaded_lit", kernel_loaded, 1);
  endtask

  task automatic check_load_log();
    chk("write_count_lit", wr_addr_q.size(), 9);
    for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
      chk("write_addr_lit", wr_addr_q[i], i);
      chk("write_data_lit", wr_data_q[i], i + 1);
      chk("kbuf_lit", kbuf[i], i + 1);
    end
  endtask

  task automatic sweep(input int nw, input bit stall, input int rst_at,
                       output int ntaps, output bit done_after_last);
    bit hs, stalled;
    int budget;
    ntaps = 0; done_after_last = 1'b0; stalled = 1'b0; budget = 0;
    num_windows = CW'(nw); run_start = 1'b1; tick(); run_start = 1'b0;
    tap_ready = 1'b1;
    while (budget < 300) begin
      if (rst_at >= 0 && tap_valid && ntaps == rst_at) begin
        chk("rst_point_addr_lit", kr_rd_addr, 5);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        return;
      end
      if (stall && !stalled && ntaps == 4) begin
        stalled = 1'b1; tap_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("stall_addr_lit", kr_rd_addr, 4);
          chk("stall_valid_lit", tap_valid, 1);
        end
        tap_ready = 1'b1;
      end
      hs = tap_valid && tap_ready;
      tick(); budget++;
      if (hs) ntaps++;
      if (done) begin done_after_last = hs; break; end
    end
  endtask

  task automatic check_tap_log();
    chk("tap_count_lit", tp_addr_q.size(), 18);
    for (int i = 0; i < 18 && i < tp_addr_q.size(); i++) begin
      chk("tap_addr_lit", tp_addr_q[i], i % 9);
      chk("tap_first_lit", tp_first_q[i], (i == 0 || i == 9) ? 1 : 0);
      chk("tap_last_lit", tp_last_q[i], (i == 8 || i == 17) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nt;
    bit  dal;
    i_rst = 1'b1; load_start = 1'b0; w_valid = 1'b0; w_data = '0;
    run_start = 1'b0; num_windows = '0; tap_ready = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
    chk("reset_outputs_lit", outs_all, 0);

    // run without a kernel
    num_windows = CW'(2); run_start = 1'b1; tick(); run_start = 1'b0;
    chk("err_no_kernel_lit", err_no_kernel, 1);
    chk("err_no_tap_lit", tap_valid, 0);
    tick();
    chk("err_pulse_end_lit", err_no_kernel, 0);

    clear_logs(); load_kernel(1'b0); check_load_log();
    tick();
    chk("load_done_pulse_end_lit", done, 0);

    clear_logs(); sweep(2, 1'b0, -1, nt, dal);
    chk("sweep_taps_lit", nt, 18);
    chk("sweep_done_timing_lit", dal, 1);
    check_tap_log();
    tick();
    chk("sweep_done_pulse_end_lit", done, 0);

    clear_logs(); load_kernel(1'b1); check_load_log();

    clear_logs(); sweep(2, 1'b1, -1, nt, dal);
    chk("stall_sweep_taps_lit", nt, 18);
    chk("stall_sweep_done_timing_lit", dal, 1);
    check_tap_log();

    // zero windows: done only
    num_windows = '0; run_start = 1'b1; tick(); run_start = 1'b0;
    chk("zero_win_done_lit", done, 1);
    chk("zero_win_no_tap_lit", tap_valid, 0);
    chk("zero_win_busy_lit", busy, 0);

    // simultaneous load_start and run_start: load wins
    num_windows = CW'(1); load_start = 1'b1; run_start = 1'b1; tick();
    load_start = 1'b0; run_start = 1'b0;
    chk("both_cmd_ready_lit", w_ready, 1);
    chk("both_cmd_no_tap_lit", tap_valid, 0);
    chk("both_cmd_kl_lit", kernel_loaded, 0);
    clear_logs(); load_kernel(1'b0); check_load_log();

    // reset at tap 5
    clear_logs(); sweep(2, 1'b0, 5, nt, dal);
    chk("mid_sweep_rst_outputs_lit", outs_all, 0);
    chk("mid_sweep_rst_kl_lit", kernel_loaded, 0);
    num_windows = CW'(1); run_start = 1'b1; tick(); run_start = 1'b0;
    chk("post_rst_err_lit", err_no_kernel, 1);
    chk("post_rst_no_tap_lit", tap_valid, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
